// File: rtl/str_to_bus_deser_pkg.sv
// Shared types and constants for the byte-stream to address/data bus deserializer.
// Holds the bus payload, the byte-array view of it, the FSM states and the byte-order mapping.
package str_to_bus_deser_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned PKT_LEN = 8;
    localparam int unsigned CNT_W   = $clog2(PKT_LEN);
    localparam int unsigned ADR_W   = 32;
    localparam int unsigned DAT_W   = 32;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

    // Byte k of a packet lands in element SLOT_BASE - k, so the first byte is most significant.
    localparam logic [CNT_W-1:0] SLOT_BASE = CNT_W'(PKT_LEN - 1);

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } t_bus;

    typedef logic [PKT_LEN-1:0][BYTE_W-1:0] t_str;

    typedef union packed {
        t_bus b;
        t_str s;
    } t_uni;

    typedef enum logic [0:0] {
        COL = 1'b0,
        DRP = 1'b1
    } t_state;

    function automatic logic [CNT_W-1:0] byte_slot(input logic [CNT_W-1:0] k);
        return SLOT_BASE - k;
    endfunction

endpackage

// File: rtl/str_bus_oreg.sv
// One-entry valid/ready output register holding an assembled bus word.
// A load in the same cycle as a transfer keeps valid high with the new word.
module str_bus_oreg
    import str_to_bus_deser_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  t_bus i_bus,
    input  logic i_rdy,
    output logic o_vld,
    output t_bus o_bus
);

    logic r_vld;
    t_bus r_bus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_bus <= '0;
        end else if (i_load) begin
            r_vld <= 1'b1;
            r_bus <= i_bus;
        end else if (r_vld && i_rdy) begin
            r_vld <= 1'b0;
        end
    end

    assign o_vld = r_vld;
    assign o_bus = r_bus;

endmodule

// File: rtl/str_to_bus_deser.sv
// Collects 8-byte packets from a byte stream into an address/data bus word,
// dropping mis-framed packets and counting delivered packets and framing errors.
module str_to_bus_deser
    import str_to_bus_deser_pkg::*;
#(
    parameter int unsigned PCW = 16,
    parameter int unsigned ECW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [7:0]       in_dat,
    input  logic             in_lst,
    output logic             out_vld,
    input  logic             out_rdy,
    output t_bus             out_bus,
    output logic             err,
    output logic [PCW-1:0]   pkt_cnt,
    output logic [ECW-1:0]   err_cnt
);

    t_state           r_state;
    t_state           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    t_uni             r_asm;
    t_uni             w_asm_nxt;
    t_uni             w_asm_fill;
    logic             w_acc;
    logic             w_load;
    logic             w_err_set;
    logic             w_out_vld;
    logic             r_err;
    logic [PCW-1:0]   r_pkt_cnt;
    logic [ECW-1:0]   r_err_cnt;

    // Stall only the final byte while a previous word is still waiting downstream.
    assign in_rdy = !((r_state == COL) && (r_cnt == LAST_IDX) && w_out_vld && !out_rdy);
    assign w_acc  = in_vld && in_rdy;

    always_comb begin
        w_asm_fill = r_asm;
        w_asm_fill.s[byte_slot(r_cnt)] = in_dat;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_asm_nxt   = r_asm;
        w_load      = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            COL: begin
                if (w_acc) begin
                    if (r_cnt == LAST_IDX) begin
                        w_cnt_nxt = '0;
                        w_asm_nxt = '0;
                        if (in_lst) begin
                            w_load = 1'b1;
                        end else begin
                            w_err_set   = 1'b1;
                            w_state_nxt = DRP;
                        end
                    end else if (in_lst) begin
                        w_err_set = 1'b1;
                        w_cnt_nxt = '0;
                        w_asm_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        w_asm_nxt = w_asm_fill;
                    end
                end
            end
            DRP: begin
                if (w_acc && in_lst) begin
                    w_state_nxt = COL;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = COL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COL;
            r_cnt   <= '0;
            r_asm   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_asm   <= w_asm_nxt;
        end
    end

    // Error pulse and counters; packet count wraps, error count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_err_set;
            if (w_load) begin
                r_pkt_cnt <= r_pkt_cnt + PCW'(1);
            end
            if (w_err_set && (r_err_cnt != {ECW{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ECW'(1);
            end
        end
    end

    str_bus_oreg u_oreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_bus  (w_asm_fill.b),
        .i_rdy  (out_rdy),
        .o_vld  (w_out_vld),
        .o_bus  (out_bus)
    );

    assign out_vld = w_out_vld;
    assign err     = r_err;
    assign pkt_cnt = r_pkt_cnt;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_str_to_bus_deser.sv
// Directed bench for str_to_bus_deser: framing, back-pressure, reset and counter limits.
// The packet counter is narrowed to 8 bits so its wrap is reachable in a short run.
module tb_str_to_bus_deser;
    import str_to_bus_deser_pkg::*;

    localparam int unsigned PCW = 8;
    localparam int unsigned ECW = 8;

    logic           clk;
    logic           rst_n;
    logic           in_vld;
    logic           in_rdy;
    logic [7:0]     in_dat;
    logic           in_lst;
    logic           out_vld;
    logic           out_rdy;
    t_bus           out_bus;
    logic           err;
    logic [PCW-1:0] pkt_cnt;
    logic [ECW-1:0] err_cnt;

    int   n_tests;
    int   n_fail;
    int   n_err_seen;
    t_bus words[$];

    str_to_bus_deser #(.PCW(PCW), .ECW(ECW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .in_dat  (in_dat),
        .in_lst  (in_lst),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_bus (out_bus),
        .err     (err),
        .pkt_cnt (pkt_cnt),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record delivered words and err pulses as they happen.
    always @(posedge clk) begin
        if (rst_n && out_vld && out_rdy) words.push_back(out_bus);
        if (rst_n && err) n_err_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one byte and hold it until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        in_vld = 1'b1;
        in_dat = d;
        in_lst = l;
        do begin
            @(posedge clk);
            t++;
        end while (!in_rdy && t < 200);
        if (t >= 200) check("send_timeout", 64'(t), 64'(0));
        #1;
        in_vld = 1'b0;
        in_lst = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] first);
        for (int i = 0; i < 8; i++) send(first + 8'(i), (i == 7));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [63:0] exp);
        t_bus w;
        check({tag, "_present"}, 64'(words.size() > 0), 64'(1));
        if (words.size() > 0) begin
            w = words.pop_front();
            check(tag, w, exp);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; n_err_seen = 0;
        rst_n = 1'b0; in_vld = 1'b0; in_dat = '0; in_lst = 1'b0; out_rdy = 1'b1;
        idle(3);
        #2 rst_n = 1'b1;
        idle(1);

        // Reset values
        check("rst_out_vld", 64'(out_vld), 64'(0));
        check("rst_out_bus", out_bus, 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        check("rst_err_cnt", 64'(err_cnt), 64'(0));
        check("rst_in_rdy", 64'(in_rdy), 64'(1));

        // Basic packet 11..18, one-cycle latency to out_vld
        send_pkt(8'h11);
        check("p1_vld", 64'(out_vld), 64'(1));
        check("p1_bus", out_bus, 64'h11121314_15161718);
        check("p1_pkt_cnt", 64'(pkt_cnt), 64'(1));
        idle(1);
        check("p1_vld_clr", 64'(out_vld), 64'(0));
        check_word("p1_word", 64'h11121314_15161718);
        check("p1_no_err", 64'(n_err_seen), 64'(0));

        // Back-to-back packets with downstream stalled 12 cycles after the first word
        out_rdy = 1'b0;
        send_pkt(8'hA0);
        fork
            send_pkt(8'hB0);
            begin
                repeat (10) @(negedge clk);
                check("bp_in_rdy_low", 64'(in_rdy), 64'(0));
                check("bp_hold_bus", out_bus, 64'hA0A1A2A3_A4A5A6A7);
                repeat (2) @(negedge clk);
                out_rdy = 1'b1;
            end
        join
        check("bp_vld_kept", 64'(out_vld), 64'(1));
        check("bp_new_bus", out_bus, 64'hB0B1B2B3_B4B5B6B7);
        idle(2);
        check_word("bp_word_a", 64'hA0A1A2A3_A4A5A6A7);
        check_word("bp_word_b", 64'hB0B1B2B3_B4B5B6B7);
        check("bp_pkt_cnt", 64'(pkt_cnt), 64'(3));

        // Short packet (3 bytes) then a good one
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b1);
        check("short_err", 64'(err), 64'(1));
        check("short_err_cnt", 64'(err_cnt), 64'(1));
        idle(1);
        check("short_err_pulse", 64'(err), 64'(0));
        check("short_no_word", 64'(words.size()), 64'(0));
        send_pkt(8'h21);
        idle(2);
        check_word("short_next", 64'h21222324_25262728);
        check("short_pkt_cnt", 64'(pkt_cnt), 64'(4));

        // Long packet (10 bytes): error after byte 8, bytes 9-10 dropped
        for (int i = 0; i < 8; i++) send(8'h31 + 8'(i), 1'b0);
        check("long_err", 64'(err), 64'(1));
        check("long_err_cnt", 64'(err_cnt), 64'(2));
        send(8'h39, 1'b0);
        check("long_drp_no_err", 64'(err), 64'(0));
        send(8'h3A, 1'b1);
        send_pkt(8'h41);
        idle(2);
        check("long_err_total", 64'(n_err_seen), 64'(2));
        check_word("long_next", 64'h41424344_45464748);
        check("long_only_one", 64'(words.size()), 64'(0));

        // Reset with a pending word and a partial packet
        out_rdy = 1'b0;
        send_pkt(8'h61);
        for (int i = 0; i < 4; i++) send(8'h51 + 8'(i), 1'b0);
        rst_n = 1'b0;
        #1;
        check("mrst_out_vld", 64'(out_vld), 64'(0));
        check("mrst_out_bus", out_bus, 64'(0));
        check("mrst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        check("mrst_err_cnt", 64'(err_cnt), 64'(0));
        check("mrst_in_rdy", 64'(in_rdy), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        out_rdy = 1'b1;
        idle(1);
        send_pkt(8'h71);
        idle(2);
        check_word("mrst_next", 64'h71727374_75767778);
        check("mrst_no_err", 64'(n_err_seen), 64'(2));

        // Error counter saturation
        for (int i = 0; i < 255; i++) send(8'h00, 1'b1);
        idle(1);
        check("sat_err_cnt_255", 64'(err_cnt), 64'hFF);
        send(8'h00, 1'b1);
        idle(1);
        check("sat_err_cnt_256", 64'(err_cnt), 64'hFF);

        // Packet counter wrap (one packet already delivered since reset)
        for (int i = 0; i < 254; i++) send_pkt(8'(i));
        idle(1);
        check("wrap_pkt_cnt_ff", 64'(pkt_cnt), 64'hFF);
        send_pkt(8'hC0);
        check("wrap_pkt_cnt_0", 64'(pkt_cnt), 64'(0));
        idle(2);
        check("wrap_word_count", 64'(words.size()), 64'(255));
        check("wrap_last_word", words[$], 64'hC0C1C2C3_C4C5C6C7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
